// File: rtl/gctr_stream_if.sv
// Handshake bundle between the GCM controller and the GCTR engine.
//   Key channel   : iKey, iKeylen, iKey_valid -> oKey_ready
//   IV channel    : iIV, iCtr0, iIV_valid
//   Block channel : iMode, iBlock, iBlock_bytes, iBlock_last, iBlock_valid / oBlock_ready
//   Result channel: oResult, oResult_last, oResult_valid / iResult_ready
// master = controller side, slave = engine side.
interface gctr_stream_if #(
  parameter int IV_W  = 96,
  parameter int CTR_W = 32
);
  logic [255:0]     iKey;
  logic             iKeylen;
  logic             iKey_valid;
  logic             oKey_ready;
  logic [IV_W-1:0]  iIV;
  logic [CTR_W-1:0] iCtr0;
  logic             iIV_valid;
  logic [1:0]       iMode;
  logic [127:0]     iBlock;
  logic [3:0]       iBlock_bytes;
  logic             iBlock_last;
  logic             iBlock_valid;
  logic             oBlock_ready;
  logic [127:0]     oResult;
  logic             oResult_last;
  logic             oResult_valid;
  logic             iResult_ready;

  modport master (
    output iKey, iKeylen, iKey_valid, iIV, iCtr0, iIV_valid,
           iMode, iBlock, iBlock_bytes, iBlock_last, iBlock_valid, iResult_ready,
    input  oKey_ready, oBlock_ready, oResult, oResult_last, oResult_valid
  );

  modport slave (
    input  iKey, iKeylen, iKey_valid, iIV, iCtr0, iIV_valid,
           iMode, iBlock, iBlock_bytes, iBlock_last, iBlock_valid, iResult_ready,
    output oKey_ready, oBlock_ready, oResult, oResult_last, oResult_valid
  );
endinterface

// File: rtl/gctr_stream.sv
// gctr_stream: streaming GCTR engine for AES-GCM. Produces H = E(K,0), the
// pre-counter mask E(K,J0) and keystream-XORed data blocks, one block in flight.
// Ports:
//   iClk  - clock
//   iRstn - asynchronous active-low reset (also resets the AES core)
//   bus   - gctr_stream_if.slave: key/IV/block inputs, result output
// Also contains aes_core: iterative AES-128/256 encryptor, one round per cycle,
// round keys expanded one word per cycle after iInit.
//   iInit/iKey/iKeylen - start key expansion; iNext/iBlock - start encryption
//   oReady - keyed and idle; oResult/oResult_valid - ciphertext, 1-cycle pulse

module aes_core (
  input  logic         iClk,
  input  logic         iRstn,
  input  logic         iInit,
  input  logic         iNext,
  input  logic         iKeylen,
  input  logic [255:0] iKey,
  input  logic [127:0] iBlock,
  output logic         oReady,
  output logic [127:0] oResult,
  output logic         oResult_valid
);
  // 64 entries so every 6-bit word index is in range; only 0..59 are used.
  logic [31:0]  w [64];
  logic [5:0]   kidx;
  logic         kexp, keyed, klen, busy, res_vld;
  logic [3:0]   rnd, nr;
  logic [127:0] st, rk0, rk_cur;
  logic [31:0]  kw_t, kw_new;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box = affine(a^254); a^254 is the field inverse (and maps 0 to 0).
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, a);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] j);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 1; i < 16; i++) begin
      if (i < int'(j)) r = xt(r);
    end
    return r;
  endfunction

  // Byte k of a 128-bit word sits at bits [127-8k -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic fin);
    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) sb[k] = sbox(s[127-8*k -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (fin) begin
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                             xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
      end
    end
    return o ^ rk;
  endfunction

  assign nr     = klen ? 4'd14 : 4'd10;
  assign rk0    = {w[0], w[1], w[2], w[3]};
  assign rk_cur = {w[{rnd, 2'd0}], w[{rnd, 2'd1}], w[{rnd, 2'd2}], w[{rnd, 2'd3}]};

  // Next expanded key word w[kidx].
  always_comb begin
    kw_t = w[kidx - 6'd1];
    if (klen) begin
      if (kidx[2:0] == 3'd0)
        kw_t = sub_word({kw_t[23:0], kw_t[31:24]}) ^ {rcon({1'b0, kidx[5:3]}), 24'h0};
      else if (kidx[2:0] == 3'd4)
        kw_t = sub_word(kw_t);
      kw_new = w[kidx - 6'd8] ^ kw_t;
    end else begin
      if (kidx[1:0] == 2'd0)
        kw_t = sub_word({kw_t[23:0], kw_t[31:24]}) ^ {rcon(kidx[5:2]), 24'h0};
      kw_new = w[kidx - 6'd4] ^ kw_t;
    end
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      for (int i = 0; i < 64; i++) w[i] <= '0;
      kidx    <= '0;
      kexp    <= 1'b0;
      keyed   <= 1'b0;
      klen    <= 1'b0;
      busy    <= 1'b0;
      rnd     <= '0;
      st      <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= 1'b0;
      if (iInit) begin
        klen  <= iKeylen;
        kexp  <= 1'b1;
        keyed <= 1'b0;
        busy  <= 1'b0;
        // AES-128 keys occupy the upper half; words 4..7 get overwritten by expansion.
        for (int i = 0; i < 8; i++) w[i] <= iKey[32*(7-i) +: 32];
        kidx  <= iKeylen ? 6'd8 : 6'd4;
      end else if (kexp) begin
        w[kidx] <= kw_new;
        kidx    <= kidx + 6'd1;
        if (kidx == (klen ? 6'd59 : 6'd43)) begin
          kexp  <= 1'b0;
          keyed <= 1'b1;
        end
      end else if (iNext && keyed && !busy) begin
        st   <= iBlock ^ rk0;
        rnd  <= 4'd1;
        busy <= 1'b1;
      end else if (busy) begin
        st <= aes_round(st, rk_cur, rnd == nr);
        if (rnd == nr) begin
          busy    <= 1'b0;
          res_vld <= 1'b1;
        end else begin
          rnd <= rnd + 4'd1;
        end
      end
    end
  end

  assign oReady        = keyed & ~busy & ~kexp;
  assign oResult       = st;
  assign oResult_valid = res_vld;
endmodule

module gctr_stream #(
  parameter int IV_W  = 96,
  parameter int CTR_W = 32
) (
  input logic         iClk,
  input logic         iRstn,
  gctr_stream_if.slave bus
);
  if (IV_W + CTR_W != 128) begin : g_bad_width
    $error("gctr_stream: IV_W + CTR_W must equal 128");
  end

  localparam logic [1:0] MODE_HASHKEY = 2'b01;
  localparam logic [1:0] MODE_Y0      = 2'b10;

  typedef enum logic [2:0] {IDLE, KEYEXP, READY, CIPHER, HOLD} state_t;
  state_t state, state_next;

  logic             load_key, load_iv, take_blk, take_res, set_kr;
  logic [255:0]     key_r;
  logic             klen_r;
  logic             aes_init, aes_next, aes_ready, aes_res_vld;
  logic [127:0]     aes_in, aes_res;
  logic [IV_W-1:0]  iv;
  logic [CTR_W-1:0] ctr;
  logic [127:0]     blk;
  logic [1:0]       mode;
  logic [3:0]       nbytes;
  logic             last;
  logic             key_ready;
  logic [127:0]     result;
  logic             result_last;

  function automatic logic is_data(input logic [1:0] m);
    return (m != MODE_HASHKEY) && (m != MODE_Y0);
  endfunction

  // Keep the first n bytes (MSB first), zero the rest; n = 0 means all 16.
  function automatic logic [127:0] mask_bytes(input logic [127:0] d, input logic [3:0] n);
    logic [127:0] m;
    m = '0;
    for (int k = 0; k < 16; k++) begin
      if (n == 4'd0 || k < int'(n)) m[127-8*k -: 8] = d[127-8*k -: 8];
    end
    return m;
  endfunction

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_key   = 1'b0;
    load_iv    = 1'b0;
    take_blk   = 1'b0;
    take_res   = 1'b0;
    set_kr     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.iKey_valid) begin
          load_key   = 1'b1;
          state_next = KEYEXP;
        end else if (bus.iIV_valid) begin
          load_iv = 1'b1;
        end
      end
      KEYEXP: begin
        // oReady seen while init is still on the wire belongs to the old key.
        if (aes_ready && !aes_init) begin
          set_kr     = 1'b1;
          state_next = READY;
        end
      end
      READY: begin
        if (bus.iKey_valid) begin
          load_key   = 1'b1;
          state_next = KEYEXP;
        end else if (bus.iIV_valid) begin
          load_iv = 1'b1;
        end else if (bus.iBlock_valid) begin
          take_blk   = 1'b1;
          state_next = CIPHER;
        end
      end
      CIPHER: begin
        if (aes_res_vld) begin
          take_res   = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (bus.iResult_ready) state_next = READY;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      key_r       <= '0;
      klen_r      <= 1'b0;
      aes_init    <= 1'b0;
      aes_next    <= 1'b0;
      aes_in      <= '0;
      iv          <= '0;
      ctr         <= '0;
      blk         <= '0;
      mode        <= '0;
      nbytes      <= '0;
      last        <= 1'b0;
      key_ready   <= 1'b0;
      result      <= '0;
      result_last <= 1'b0;
    end else begin
      aes_init <= load_key;
      aes_next <= take_blk;
      if (load_key) begin
        key_r     <= bus.iKey;
        klen_r    <= bus.iKeylen;
        key_ready <= 1'b0;
      end else if (set_kr) begin
        key_ready <= 1'b1;
      end
      if (load_iv) begin
        iv  <= bus.iIV;
        ctr <= bus.iCtr0;
      end
      if (take_blk) begin
        blk    <= bus.iBlock;
        mode   <= bus.iMode;
        nbytes <= bus.iBlock_bytes;
        last   <= bus.iBlock_last;
        case (bus.iMode)
          MODE_HASHKEY: aes_in <= '0;
          MODE_Y0:      aes_in <= {iv, CTR_W'(1)};
          default: begin
            aes_in <= {iv, ctr};
            ctr    <= ctr + 1'b1;
          end
        endcase
      end
      if (take_res) begin
        result      <= is_data(mode) ? mask_bytes(aes_res ^ blk, nbytes) : aes_res;
        result_last <= last;
      end
    end
  end

  aes_core u_aes (
    .iClk          (iClk),
    .iRstn         (iRstn),
    .iInit         (aes_init),
    .iNext         (aes_next),
    .iKeylen       (klen_r),
    .iKey          (key_r),
    .iBlock        (aes_in),
    .oReady        (aes_ready),
    .oResult       (aes_res),
    .oResult_valid (aes_res_vld)
  );

  assign bus.oKey_ready    = key_ready;
  assign bus.oBlock_ready  = (state == READY) & ~bus.iKey_valid & ~bus.iIV_valid;
  assign bus.oResult_valid = (state == HOLD);
  assign bus.oResult       = result;
  assign bus.oResult_last  = result_last;
endmodule

// File: tb/tb_gctr_stream.sv
module tb_gctr_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gctr_stream_if #(.IV_W(96), .CTR_W(32)) bus ();

  gctr_stream #(.IV_W(96), .CTR_W(32)) dut (
    .iClk  (clk),
    .iRstn (rst_n),
    .bus   (bus)
  );

  localparam logic [127:0] E128_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] E128_Y0   = 128'h58e2fccefa7e3061367f1d57a4e7455a;
  localparam logic [127:0] E128_CTR2 = 128'h0388dace60b6a392f328c2b971b2fe78;
  localparam logic [127:0] E128_PART = 128'h0388dace000000000000000000000000;
  localparam logic [127:0] E256_ZERO = 128'hdc95c078a2408989ad48a21492842087;
  localparam logic [127:0] E256_Y0   = 128'h530f8afbc74536b9a963b4f1c4cb738b;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE or READY.
  task automatic do_key(input logic klen);
    int   cyc;
    logic br_seen;
    bus.iKey       = '0;
    bus.iKeylen    = klen;
    bus.iKey_valid = 1'b1;
    @(negedge clk);
    bus.iKey_valid = 1'b0;
    check("key_ready_cleared", bus.oKey_ready, 0);
    cyc     = 0;
    br_seen = 1'b0;
    while (!bus.oKey_ready && cyc < 500) begin
      br_seen = br_seen | bus.oBlock_ready;
      @(negedge clk);
      cyc++;
    end
    check("key_ready_timeout", bus.oKey_ready, 1);
    check("block_ready_in_keyexp", br_seen, 0);
    check("keyexp_not_early", cyc >= 40, 1);
  endtask

  task automatic load_iv(input logic [95:0] iv, input logic [31:0] c0);
    bus.iIV       = iv;
    bus.iCtr0     = c0;
    bus.iIV_valid = 1'b1;
    @(negedge clk);
    bus.iIV_valid = 1'b0;
  endtask

  // Called at a negedge in READY. With hold=0 the output handshake is completed.
  task automatic send_block(input logic [1:0] mode, input logic [127:0] blk,
                            input logic [3:0] nb, input logic lst, input logic hold,
                            output logic [127:0] res, output logic rlast, output int lat);
    int cyc;
    bus.iMode        = mode;
    bus.iBlock       = blk;
    bus.iBlock_bytes = nb;
    bus.iBlock_last  = lst;
    bus.iBlock_valid = 1'b1;
    #1;
    cyc = 0;
    while (!bus.oBlock_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("block_accept_timeout", bus.oBlock_ready, 1);
    @(negedge clk);
    bus.iBlock_valid = 1'b0;
    check("block_ready_drop", bus.oBlock_ready, 0);
    lat = 0;
    while (!bus.oResult_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("result_timeout", bus.oResult_valid, 1);
    res   = bus.oResult;
    rlast = bus.oResult_last;
    if (!hold) begin
      @(negedge clk);
      check("result_valid_drop", bus.oResult_valid, 0);
      check("block_ready_return", bus.oBlock_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] res, r1;
    logic         rlast, stable;
    int           lat;

    bus.iKey = '0; bus.iKeylen = 1'b0; bus.iKey_valid = 1'b0;
    bus.iIV = '0; bus.iCtr0 = '0; bus.iIV_valid = 1'b0;
    bus.iMode = '0; bus.iBlock = '0; bus.iBlock_bytes = '0; bus.iBlock_last = 1'b0;
    bus.iBlock_valid = 1'b0; bus.iResult_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_key_ready", bus.oKey_ready, 0);
    check("rst_block_ready", bus.oBlock_ready, 0);
    check("rst_result_valid", bus.oResult_valid, 0);
    check("rst_result", bus.oResult, 0);
    check("rst_result_last", bus.oResult_last, 0);
    check("rst_ctr", dut.ctr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // AES-128, zero key
    do_key(1'b0);
    load_iv(96'h0, 32'd2);
    send_block(2'b01, '0, 4'd0, 1'b0, 1'b0, res, rlast, lat);
    check("hashkey_128", res, E128_ZERO);
    send_block(2'b10, '0, 4'd0, 1'b0, 1'b0, res, rlast, lat);
    check("y0_128", res, E128_Y0);
    check("ctr_after_hash_y0", dut.ctr, 2);

    // IV and block offered together: only the IV is taken
    bus.iIV = '0; bus.iCtr0 = 32'd2; bus.iIV_valid = 1'b1;
    bus.iMode = 2'b00; bus.iBlock = '0; bus.iBlock_bytes = 4'd0; bus.iBlock_last = 1'b0;
    bus.iBlock_valid = 1'b1;
    #1;
    check("block_ready_during_iv", bus.oBlock_ready, 0);
    @(negedge clk);
    bus.iIV_valid = 1'b0;
    check("ctr_iv_only", dut.ctr, 2);
    send_block(2'b00, '0, 4'd0, 1'b0, 1'b0, res, rlast, lat);
    check("data_ctr2", res, E128_CTR2);
    check("data_ctr2_last", rlast, 0);
    check("data_latency", lat, 12);
    check("ctr_after_data", dut.ctr, 3);

    // Partial final block
    load_iv(96'h0, 32'd2);
    send_block(2'b00, '0, 4'd4, 1'b1, 1'b0, res, rlast, lat);
    check("partial_block", res, E128_PART);
    check("partial_last", rlast, 1);

    // Reserved mode behaves as DATA
    load_iv(96'h0, 32'd2);
    send_block(2'b11, '0, 4'd0, 1'b0, 1'b0, res, rlast, lat);
    check("reserved_mode", res, E128_CTR2);

    // Counter wrap
    load_iv(96'h0, 32'hFFFF_FFFF);
    send_block(2'b00, '0, 4'd0, 1'b0, 1'b0, r1, rlast, lat);
    check("wrap_first_differs", r1 != E128_ZERO, 1);
    check("ctr_wrapped", dut.ctr, 0);
    send_block(2'b00, '0, 4'd0, 1'b0, 1'b0, res, rlast, lat);
    check("wrap_second", res, E128_ZERO);
    check("ctr_after_wrap", dut.ctr, 1);

    // Backpressure
    bus.iResult_ready = 1'b0;
    send_block(2'b01, '0, 4'd0, 1'b0, 1'b1, res, rlast, lat);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stable = stable & (bus.oResult == res) & bus.oResult_valid & ~bus.oBlock_ready;
    end
    check("hold_stable", stable, 1);
    check("hold_value", bus.oResult, E128_ZERO);
    bus.iResult_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", bus.oResult_valid, 0);
    check("hold_release_ready", bus.oBlock_ready, 1);

    // Rekey to AES-256 from READY
    do_key(1'b1);
    load_iv(96'h0, 32'd2);
    send_block(2'b01, '0, 4'd0, 1'b0, 1'b0, res, rlast, lat);
    check("hashkey_256", res, E256_ZERO);
    check("latency_256", lat, 16);
    send_block(2'b10, '0, 4'd0, 1'b0, 1'b0, res, rlast, lat);
    check("y0_256", res, E256_Y0);

    // Reset while a block is in CIPHER
    bus.iMode = 2'b00; bus.iBlock = 128'h1234; bus.iBlock_bytes = 4'd0;
    bus.iBlock_last = 1'b1; bus.iBlock_valid = 1'b1;
    @(negedge clk);
    bus.iBlock_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_state", dut.state, 3);
    rst_n = 1'b0;
    #1;
    check("midrst_key_ready", bus.oKey_ready, 0);
    check("midrst_block_ready", bus.oBlock_ready, 0);
    check("midrst_result_valid", bus.oResult_valid, 0);
    check("midrst_result", bus.oResult, 0);
    check("midrst_result_last", bus.oResult_last, 0);
    check("midrst_state", dut.state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stable = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      stable = stable | bus.oResult_valid | bus.oKey_ready;
    end
    check("post_rst_discarded", stable, 0);
    check("post_rst_state", dut.state, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
